zero_branch_engine: RTL

- Parametrised successor to the fixed-program FPGA test harnesses.
- Executes a loadable program of mov/add/sub/out/jump/compare-branch instructions, one instruction per clock, against a local register file.
- Streams `out` values through a valid/ready channel.
- Adds signed/unsigned compare mode, output backpressure, step-limit timeout and illegal-opcode detection, so one block replaces per-test generated modules.

---
 rtl/zero_branch_engine_if.sv | 27 ++
 rtl/zero_branch_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/zero_branch_engine_if.sv
// Load and output channels of the zero-branch program engine.
// The engine takes the slave side: it receives instruction writes and
// drives the valid/ready output stream.
interface zero_branch_engine_if #(
  parameter int W  = 12,
  parameter int IA = 7,
  parameter int LA = 4
);
  localparam int IW = 4 + 1 + LA + W + IA;

  logic          load_valid;
  logic [IA-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  modport master (
    output load_valid, load_addr, load_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  load_valid, load_addr, load_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/zero_branch_engine.sv
// Loadable-program execution engine: one instruction per clock against a
// local register file, with a backpressured output stream, step-limit
// timeout and illegal-opcode detection.
// Instruction word layout: {op[3:0], bIsReg, a[LA-1:0], b[W-1:0], target[IA-1:0]}.
module zero_branch_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal             = 16,
  parameter int NInstructions      = 128,
  parameter int MaxSteps           = 256,
  parameter int SignedCompare      = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  zero_branch_engine_if.slave                bus,
  input  logic                               start,
  output logic                               busy,
  output logic                               finished,
  output logic [1:0]                         error,
  output logic [$clog2(NInstructions):0]     ip,
  output logic [$clog2(MaxSteps+1)-1:0]      steps
);

  localparam int W   = MemoryElementWidth;
  localparam int LA  = $clog2(NLocal);
  localparam int IA  = $clog2(NInstructions);
  localparam int IPW = IA + 1;
  localparam int SW  = $clog2(MaxSteps + 1);
  localparam int IW  = 4 + 1 + LA + W + IA;

  localparam logic [3:0] OpMov = 4'd1, OpAdd = 4'd2, OpSub = 4'd3, OpOut = 4'd4;
  localparam logic [3:0] OpJmp = 4'd5, OpJEq = 4'd6, OpJNe = 4'd7, OpJLt = 4'd8;
  localparam logic [3:0] OpJLe = 4'd9, OpJGt = 4'd10, OpJGe = 4'd11, OpJTrue = 4'd12;
  localparam logic [3:0] OpJFalse = 4'd13, OpHalt = 4'd14, OpIllegal = 4'd15;

  localparam logic [1:0] ErrNone = 2'd0, ErrTimeout = 2'd1, ErrIllegal = 2'd2;

  typedef enum logic [1:0] {Idle, Run, Stall, Done} engineState_t;

  engineState_t  state;
  logic          timeoutPend;
  logic [IW-1:0] imem   [NInstructions];
  logic [W-1:0]  locals [NLocal];

  logic [IW-1:0]        instr;
  logic [3:0]           op;
  logic                 bIsReg;
  logic [LA-1:0]        aIdx;
  logic [W-1:0]         bImm;
  logic [IA-1:0]        target;
  logic [W-1:0]         opA, opB, aluResult;
  logic signed [W-1:0]  opASigned, opBSigned;
  logic                 equal, lessThan, taken, writesLocal, offEnd, lastStep;
  logic [IPW-1:0]       ipSeq, ipTarget;
  logic [SW-1:0]        stepsInc;

  assign instr     = imem[ip[IA-1:0]];
  assign op        = instr[IW-1 -: 4];
  assign bIsReg    = instr[IW-5];
  assign aIdx      = instr[IA+W +: LA];
  assign bImm      = instr[IA +: W];
  assign target    = instr[IA-1:0];
  assign opA       = locals[aIdx];
  assign opB       = bIsReg ? locals[bImm[LA-1:0]] : bImm;
  assign opASigned = $signed(opA);
  assign opBSigned = $signed(opB);
  assign equal     = (opA == opB);
  assign lessThan  = (SignedCompare != 0) ? (opASigned < opBSigned) : (opA < opB);
  assign ipSeq     = ip + IPW'(1);
  assign ipTarget  = {1'b0, target};
  assign offEnd    = (ip >= IPW'(NInstructions));
  assign stepsInc  = steps + SW'(1);
  assign lastStep  = (stepsInc == SW'(MaxSteps));

  // Branch decision and register-file write value for the fetched instruction.
  always_comb begin
    taken       = 1'b0;
    aluResult   = opA;
    writesLocal = 1'b0;
    case (op)
      OpMov:    begin aluResult = opB;       writesLocal = 1'b1; end
      OpAdd:    begin aluResult = opA + opB; writesLocal = 1'b1; end
      OpSub:    begin aluResult = opA - opB; writesLocal = 1'b1; end
      OpJmp:    taken = 1'b1;
      OpJEq:    taken = equal;
      OpJNe:    taken = !equal;
      OpJLt:    taken = lessThan;
      OpJLe:    taken = lessThan || equal;
      OpJGt:    taken = !(lessThan || equal);
      OpJGe:    taken = !lessThan;
      OpJTrue:  taken = (opA != '0);
      OpJFalse: taken = (opA == '0);
      default:  taken = 1'b0;
    endcase
  end

  // Instruction memory write port; only accepted while no program is running.
  always_ff @(posedge clock) begin
    if (bus.load_valid && (state == Idle || state == Done))
      imem[bus.load_addr] <= bus.load_data;
  end

  // Control FSM with registered status, output channel and register file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= Idle;
      busy          <= 1'b0;
      finished      <= 1'b0;
      error         <= ErrNone;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      ip            <= '0;
      steps         <= '0;
      timeoutPend   <= 1'b0;
      for (int i = 0; i < NLocal; i++) locals[i] <= '0;
    end else begin
      case (state)
        Idle, Done: begin
          if (start) begin
            state       <= Run;
            busy        <= 1'b1;
            finished    <= 1'b0;
            error       <= ErrNone;
            ip          <= '0;
            steps       <= '0;
            timeoutPend <= 1'b0;
            for (int i = 0; i < NLocal; i++) locals[i] <= '0;
          end
        end
        Run: begin
          if (offEnd) begin
            state    <= Done;
            busy     <= 1'b0;
            finished <= 1'b1;
            error    <= ErrNone;
          end else begin
            case (op)
              OpIllegal: begin
                // ip stays on the offending word; it is not counted as executed
                state    <= Done;
                busy     <= 1'b0;
                finished <= 1'b1;
                error    <= ErrIllegal;
              end
              OpHalt: begin
                // a halt on the final permitted step still ends cleanly
                steps    <= stepsInc;
                state    <= Done;
                busy     <= 1'b0;
                finished <= 1'b1;
                error    <= ErrNone;
              end
              OpOut: begin
                // the timeout is deferred until the word has been accepted
                steps         <= stepsInc;
                bus.out_data  <= opB;
                bus.out_valid <= 1'b1;
                timeoutPend   <= lastStep;
                state         <= Stall;
              end
              default: begin
                steps <= stepsInc;
                ip    <= taken ? ipTarget : ipSeq;
                if (writesLocal) locals[aIdx] <= aluResult;
                if (lastStep) begin
                  state    <= Done;
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  error    <= ErrTimeout;
                end
              end
            endcase
          end
        end
        Stall: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            ip            <= ipSeq;
            if (timeoutPend) begin
              state    <= Done;
              busy     <= 1'b0;
              finished <= 1'b1;
              error    <= ErrTimeout;
            end else begin
              state <= Run;
            end
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule
